// File: rtl/signed_magnitude_display_if.sv
// signed_magnitude_display_if: switch inputs and LED/status outputs of the sign/magnitude display.
interface signed_magnitude_display_if #(
    parameter int W = 3
);
    localparam int LEDS = 2 ** (W - 1) + 1;
    logic [W-1:0] sw;
    logic mode;
    logic led_sign;
    logic [LEDS-1:0] led_mag;
    logic [W-1:0] mag;
    logic busy;
    logic update;
    modport master (output sw, mode, input led_sign, led_mag, mag, busy, update);
    modport slave (input sw, mode, output led_sign, led_mag, mag, busy, update);
endinterface

// File: rtl/signed_magnitude_display.sv
// signed_magnitude_display: synchronised, debounced two's-complement switches to sign LED,
// binary magnitude and one-hot/thermometer LED bar via a bit-serial negator.
module signed_magnitude_display #(
    parameter int W = 3,
    parameter int DEBOUNCE = 4
) (
    input logic CLOCK_50,
    input logic reset,
    signed_magnitude_display_if.slave bus
);
    localparam int LEDS = 2 ** (W - 1) + 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int BW = $clog2(W + 1);
    typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
    state_t state, state_n;
    logic [W-1:0] s1, s2, cand, committed, sh, mag_r;
    logic [DW-1:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic neg, mode_l, seen_one, stable, accept, conv_done, out_bit;
    logic [LEDS-1:0] bar;

    assign stable = (cnt == DW'(DEBOUNCE - 1)) && (s2 == cand);
    assign accept = stable && (cand != committed) && (state == IDLE);
    assign conv_done = bit_cnt == BW'(W - 1);
    // copy bits up to and including the first one, invert the rest
    assign out_bit = (neg && seen_one) ? ~sh[0] : sh[0];
    assign bus.busy = state != IDLE;

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (accept ? CONV : IDLE) :
                  (state == CONV) ? (conv_done ? SHOW : CONV) : IDLE;
    end

    always_comb begin
        bar = '0;
        for (int i = 0; i < LEDS; i++) bar[i] = mode_l ? (i <= int'(mag_r)) : (i == int'(mag_r));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            cand <= '0;
            committed <= '0;
            cnt <= '0;
            sh <= '0;
            mag_r <= '0;
            bit_cnt <= '0;
            neg <= 1'b0;
            mode_l <= 1'b0;
            seen_one <= 1'b0;
            bus.mag <= '0;
            bus.led_sign <= 1'b0;
            bus.led_mag <= LEDS'(1);
            bus.update <= 1'b0;
        end else begin
            s1 <= bus.sw;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt <= '0;
            end else if (cnt != DW'(DEBOUNCE - 1)) begin
                cnt <= cnt + 1'b1;
            end
            bus.update <= state == SHOW;
            if (accept) begin
                committed <= cand;
                sh <= cand;
                neg <= cand[W-1];
                mode_l <= bus.mode;
                seen_one <= 1'b0;
                bit_cnt <= '0;
            end
            if (state == CONV) begin
                sh <= sh >> 1;
                mag_r <= {out_bit, mag_r[W-1:1]};
                seen_one <= seen_one | sh[0];
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == SHOW) begin
                bus.mag <= mag_r;
                bus.led_sign <= neg;
                bus.led_mag <= bar;
            end
        end
    end
endmodule
